// File: rtl/ioctl_loader_seq.sv
// ioctl_loader_seq: sequencer between the HPS download stream and the core.
// It slows ROM writes down to the core's write rate, captures the mod byte
// and the DIP bank, and owns the core reset.
//
// Handshake: a ROM write is accepted on the rising clk_sys edge where
// ioctl_wr is high in IDLE. From that edge ioctl_wait and rom_wr are held
// high for WR_CYCLES cycles, with rom_addr/rom_data frozen. Any ioctl_wr
// seen while ioctl_wait is high is dropped and sets err_overrun.
module ioctl_loader_seq #(
  parameter int WR_CYCLES = 4,
  parameter int POST_RST  = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_wr,
  output logic [7:0]  mod,
  output logic [7:0]  dip0,
  output logic [7:0]  dip1,
  output logic [7:0]  dip2,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        err_overrun,
  output logic [0:0]  dbg_state_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ROMWR = 1'b1;

  localparam int WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int RCW = (POST_RST > 0) ? $clog2(POST_RST + 1) : 1;
  localparam logic [WCW-1:0] WR_LAST  = WCW'(WR_CYCLES - 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(POST_RST);

  logic [0:0]     state_q, state_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [15:0]    rom_addr_q;
  logic [7:0]     rom_data_q;
  logic [7:0]     mod_q;
  logic [7:0]     dip_q [8];
  logic           err_q;
  logic           rom_dl_q;
  logic           byte_seen_q;
  logic           rom_loaded_q;

  logic in_idle;
  logic rom_dl;
  logic rom_accept;
  logic mod_wr;
  logic dip_wr;
  logic overrun;
  logic dl_rise;
  logic dl_fall;

  // Request decode; config writes are only honoured while no ROM write is in flight.
  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    rom_dl     = ioctl_download && (ioctl_index == 8'd0);
    rom_accept = in_idle && ioctl_wr && rom_dl && (ioctl_addr[24:16] == 9'd0);
    mod_wr     = in_idle && ioctl_wr && (ioctl_index == 8'd1);
    dip_wr     = in_idle && ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
    overrun    = !in_idle && ioctl_wr;
    dl_rise    = rom_dl && !rom_dl_q;
    dl_fall    = !rom_dl && rom_dl_q;
  end

  // Write pacing FSM: hold the strobe for WR_CYCLES cycles, then return to IDLE.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rom_accept) begin
          state_d  = ST_ROMWR;
          wr_cnt_d = WR_LAST;
        end
      end
      default: begin
        if (wr_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - WCW'(1);
        end
      end
    endcase
  end

  // Post-download countdown: reload on the download falling edge, freeze while
  // a ROM download is active, otherwise count down to zero and stop.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (dl_fall) begin
      rst_cnt_d = RST_LOAD;
    end else if (!rom_dl && (rst_cnt_q != '0)) begin
      rst_cnt_d = rst_cnt_q - RCW'(1);
    end
  end

  // FSM and counter state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      rst_cnt_q <= RST_LOAD;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // ROM address/data latch, loaded only on an accepted write so it stays frozen during ROMWR.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else if (rom_accept) begin
      rom_addr_q <= ioctl_addr[15:0];
      rom_data_q <= ioctl_dout;
    end
  end

  // Config capture: mod byte and the eight-byte DIP bank.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod_q <= '0;
      for (int i = 0; i < 8; i++) begin
        dip_q[i] <= '0;
      end
    end else begin
      if (mod_wr) begin
        mod_q <= ioctl_dout;
      end
      if (dip_wr) begin
        dip_q[ioctl_addr[2:0]] <= ioctl_dout;
      end
    end
  end

  // Download tracking: edge detect, bytes-seen flag, rom_loaded and the sticky overrun flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_dl_q     <= 1'b0;
      byte_seen_q  <= 1'b0;
      rom_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rom_dl_q <= rom_dl;
      if (dl_rise) begin
        byte_seen_q <= rom_accept;
      end else if (rom_accept) begin
        byte_seen_q <= 1'b1;
      end
      if (dl_rise) begin
        rom_loaded_q <= 1'b0;
      end else if (dl_fall) begin
        rom_loaded_q <= byte_seen_q;
      end
      if (overrun) begin
        err_q <= 1'b1;
      end
    end
  end

  // rom_wr/ioctl_wait come straight from the state register so an async reset
  // kills a write in flight at once. rom_dl_q covers the one cycle between the
  // download dropping and the counter being reloaded, so core_reset never glitches.
  assign rom_wr      = (state_q == ST_ROMWR);
  assign ioctl_wait  = (state_q == ST_ROMWR);
  assign rom_addr    = rom_addr_q;
  assign rom_data    = rom_data_q;
  assign mod         = mod_q;
  assign dip0        = dip_q[0];
  assign dip1        = dip_q[1];
  assign dip2        = dip_q[2];
  assign core_reset  = rom_dl || rom_dl_q || (state_q != ST_IDLE) || (rst_cnt_q != '0);
  assign rom_loaded  = rom_loaded_q;
  assign err_overrun = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ioctl_loader_seq.sv
// Testbench for ioctl_loader_seq: directed download sequences, a ROM-write
// scoreboard fed by the drivers and drained by a monitor, and direct checks
// of config registers, core_reset timing and reset behaviour.
module tb_ioctl_loader_seq;

  localparam int WR_CYCLES = 4;
  localparam int POST_RST  = 1024;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_wr;
  logic [7:0]  mod;
  logic [7:0]  dip0, dip1, dip2;
  logic        core_reset;
  logic        rom_loaded;
  logic        err_overrun;
  logic [0:0]  dbg_state;

  always #5 clk_sys = ~clk_sys;

  ioctl_loader_seq #(
    .WR_CYCLES(WR_CYCLES),
    .POST_RST (POST_RST)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_wr        (rom_wr),
    .mod           (mod),
    .dip0          (dip0),
    .dip1          (dip1),
    .dip2          (dip2),
    .core_reset    (core_reset),
    .rom_loaded    (rom_loaded),
    .err_overrun   (err_overrun),
    .dbg_state_o   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];      // {rom_addr, rom_data} of each expected ROM write
  int          exp_len_q[$];  // expected strobe length, 0 = aborted, do not check

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        wr_prev = 1'b0;
  logic [23:0] cur_exp = 24'd0;
  int          cur_len_exp = 0;
  int          cur_len = 0;

  always @(negedge clk_sys) begin
    if (rom_wr && !wr_prev) begin
      checks++;
      cur_len = 1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rom_write_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 rom_addr, rom_data);
        cur_exp     = {rom_addr, rom_data};
        cur_len_exp = 0;
      end else begin
        cur_exp     = exp_q.pop_front();
        cur_len_exp = exp_len_q.pop_front();
        if ({rom_addr, rom_data} !== cur_exp || ioctl_wait !== 1'b1) begin
          errors++;
          $display("FAIL rom_write_start: got addr 0x%0h data 0x%0h wait %0b, expected addr 0x%0h data 0x%0h wait 1",
                   rom_addr, rom_data, ioctl_wait, cur_exp[23:8], cur_exp[7:0]);
        end
      end
    end else if (rom_wr && wr_prev) begin
      cur_len++;
      checks++;
      if ({rom_addr, rom_data} !== cur_exp || ioctl_wait !== 1'b1) begin
        errors++;
        $display("FAIL rom_write_hold: got addr 0x%0h data 0x%0h wait %0b, expected addr 0x%0h data 0x%0h wait 1",
                 rom_addr, rom_data, ioctl_wait, cur_exp[23:8], cur_exp[7:0]);
      end
    end else if (!rom_wr && wr_prev && cur_len_exp != 0) begin
      checks++;
      if (cur_len != cur_len_exp || ioctl_wait !== 1'b0) begin
        errors++;
        $display("FAIL rom_write_len: got %0d cycles wait %0b, expected %0d cycles wait 0",
                 cur_len, ioctl_wait, cur_len_exp);
      end
    end
    wr_prev = rom_wr;
  end

  // ---------------- driver tasks ----------------
  // All drivers are entered and left on a falling clock edge.
  task automatic do_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    int n;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: ioctl_wait still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic rom_byte(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    exp_len_q.push_back(WR_CYCLES);
    do_write(8'd0, {9'd0, a}, d);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  // Count cycles until core_reset drops.
  task automatic measure_core_reset(input string name, input int exp_n);
    int n;
    n = 0;
    while (core_reset && n < 4000) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_wr"},      32'(rom_wr), 32'd0);
    check({tag, "_ioctl_wait"},  32'(ioctl_wait), 32'd0);
    check({tag, "_rom_addr"},    32'(rom_addr), 32'd0);
    check({tag, "_rom_data"},    32'(rom_data), 32'd0);
    check({tag, "_mod"},         32'(mod), 32'd0);
    check({tag, "_dips"},        32'({dip0, dip1, dip2}), 32'd0);
    check({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
    check({tag, "_rom_loaded"},  32'(rom_loaded), 32'd0);
    check({tag, "_core_reset"},  32'(core_reset), 32'd1);
    check({tag, "_state"},       32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values, then core_reset must drop POST_RST cycles after release.
    repeat (3) @(negedge clk_sys);
    check_reset_values("reset");
    reset_n = 1'b1;
    measure_core_reset("core_reset_after_reset_n", POST_RST);

    // DIP bank: bytes 0-3 written, address 8 must be ignored.
    start_dl(8'd254);
    check("core_reset_cfg_dl", 32'(core_reset), 32'd0);
    do_write(8'd254, 25'd0, 8'h11);
    do_write(8'd254, 25'd1, 8'h22);
    do_write(8'd254, 25'd2, 8'h33);
    do_write(8'd254, 25'd3, 8'h44);
    do_write(8'd254, 25'd8, 8'hFF);
    end_dl();
    check("dip_bank", 32'({dip0, dip1, dip2}), 32'h112233);

    // mod: any address, last write wins.
    start_dl(8'd1);
    do_write(8'd1, 25'd0, 8'h07);
    do_write(8'd1, 25'h1ABCD, 8'h02);
    end_dl();
    check("mod_last_wins", 32'(mod), 32'h02);

    // Unknown index: nothing changes, no backpressure.
    start_dl(8'd7);
    do_write(8'd7, 25'd0, 8'h99);
    check("idx7_no_wait", 32'(ioctl_wait), 32'd0);
    end_dl();
    check("idx7_ignored", 32'({mod, dip0, dip1, dip2}), 32'h02112233);

    // ROM download of 16 bytes plus one out-of-range address that is dropped.
    start_dl(8'd0);
    check("core_reset_rom_dl", 32'(core_reset), 32'd1);
    rom_byte(16'h1234, 8'hA5);
    check("rom_wr_low_after", 32'({rom_wr, ioctl_wait}), 32'd0);
    do_write(8'd0, 25'h1_0000, 8'hEE);
    check("hi_addr_no_wait", 32'(ioctl_wait), 32'd0);
    check("hi_addr_no_latch", 32'({rom_addr, rom_data}), 32'h1234A5);
    for (int i = 1; i < 16; i++) begin
      rom_byte(16'h0100 + 16'(i), 8'(i * 17));
      if (i == 8) check("core_reset_mid_dl", 32'(core_reset), 32'd1);
    end
    check("rom_loaded_during_dl", 32'(rom_loaded), 32'd0);
    end_dl();
    measure_core_reset("core_reset_after_dl", POST_RST);
    check("rom_loaded_after_dl", 32'(rom_loaded), 32'd1);

    // Empty ROM download: rom_loaded clears on start and stays clear.
    start_dl(8'd0);
    check("rom_loaded_cleared", 32'(rom_loaded), 32'd0);
    end_dl();
    check("rom_loaded_empty_dl", 32'(rom_loaded), 32'd0);

    // New ROM download at countdown 500: held high, reload at the new end.
    repeat (524) @(negedge clk_sys);
    start_dl(8'd0);
    rom_byte(16'h0042, 8'h3C);
    rom_byte(16'h0043, 8'hC3);
    repeat (50) @(negedge clk_sys);
    check("core_reset_held", 32'(core_reset), 32'd1);
    end_dl();
    measure_core_reset("core_reset_restart", POST_RST);
    check("rom_loaded_restart", 32'(rom_loaded), 32'd1);

    // Overrun: second write issued while the first is still in flight.
    start_dl(8'd0);
    check("err_overrun_clear", 32'(err_overrun), 32'd0);
    exp_q.push_back({16'h0010, 8'h5A});
    exp_len_q.push_back(WR_CYCLES);
    ioctl_addr = 25'h0010;
    ioctl_dout = 8'h5A;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'h0020;
    ioctl_dout = 8'hC3;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (6) @(negedge clk_sys);
    check("err_overrun_set", 32'(err_overrun), 32'd1);
    check("overrun_first_kept", 32'({rom_addr, rom_data}), 32'h00105A);

    // Async reset in the middle of a ROM write.
    exp_q.push_back({16'h0777, 8'h77});
    exp_len_q.push_back(0);
    ioctl_addr = 25'h0777;
    ioctl_dout = 8'h77;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("rom_wr_before_abort", 32'({rom_wr, ioctl_wait}), 32'd3);
    #2;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("abort_immediate", 32'({rom_wr, ioctl_wait}), 32'd0);
    @(negedge clk_sys);
    check_reset_values("abort");
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
